// File: rtl/event_encoder4x2_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : enc_pkg
//  Description : Shared constants and slot-state encoding for the
//                event_encoder4x2 front end and its arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int NUM_SRC = 4;
    localparam int CODE_W  = 2;

    // Arbitration mode selector fed to prio_arb4
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Output slot occupancy; FULL means code holds an untransferred event
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/event_encoder4x2_if.sv
`default_nettype none
// ============================================================================
//  Interface   : event_encoder4x2_if
//  Description : Request inputs, encoded valid/ready output and status bus
//                of the event encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface event_encoder4x2_if
    import enc_pkg::*;
#(
    parameter int DROP_W = 8
) ();

    logic [NUM_SRC-1:0] req;
    logic [CODE_W-1:0]  code;
    logic               valid;
    logic               ready;
    logic [NUM_SRC-1:0] pending;
    logic [DROP_W-1:0]  drop_cnt;

    // Encoder side
    modport slave (
        input  req,
        input  ready,
        output code,
        output valid,
        output pending,
        output drop_cnt
    );

    // Event producer / consumer side
    modport master (
        output req,
        output ready,
        input  code,
        input  valid,
        input  pending,
        input  drop_cnt
    );

endinterface : event_encoder4x2_if
`default_nettype wire

// File: rtl/event_encoder4x2_prio_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arb4
//  Description : Combinational 4-input arbiter. Fixed mode grants the highest
//                pending index; round-robin mode searches upward from the
//                source after rr_last, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arb4
    import enc_pkg::*;
(
    input  wire logic [NUM_SRC-1:0] pending,
    input  wire logic [CODE_W-1:0]  rr_last,
    input  wire logic               mode,
    output logic      [CODE_W-1:0]  gnt_idx,
    output logic                    gnt_any
);

    logic [CODE_W-1:0] w_idx;

    // Select the winning pending source; later loop iterations override
    // earlier ones, so each loop runs from lowest to highest priority.
    always_comb begin
        gnt_idx = '0;
        w_idx   = '0;
        gnt_any = |pending;
        if (mode == ARB_RR) begin
            // k = NUM_SRC wraps to rr_last itself (lowest priority),
            // k = 1 is rr_last+1 (highest priority)
            for (int k = NUM_SRC; k >= 1; k--) begin
                w_idx = rr_last + CODE_W'(k);
                if (pending[w_idx]) begin
                    gnt_idx = w_idx;
                end
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pending[i]) begin
                    gnt_idx = CODE_W'(i);
                end
            end
        end
    end

endmodule : prio_arb4
`default_nettype wire

// File: rtl/event_encoder4x2.sv
`default_nettype none
// ============================================================================
//  Module      : event_encoder4x2
//  Description : Captures event pulses from four sources into sticky pending
//                bits, arbitrates among them and presents one 2-bit source
//                index per transfer on a registered valid/ready output.
//                Counts events lost to already-pending sources.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_encoder4x2
    import enc_pkg::*;
#(
    parameter int RR_MODE = 0,
    parameter int DROP_W  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    event_encoder4x2_if.slave bus
);

    localparam logic              C_MODE    = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
    localparam logic [DROP_W-1:0] C_DROP_MAX = {DROP_W{1'b1}};

    slot_state_e         state_q,    state_d;
    logic [CODE_W-1:0]   code_q,     code_d;
    logic [NUM_SRC-1:0]  pending_q,  pending_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CODE_W-1:0]   rr_last_q,  rr_last_d;

    logic [CODE_W-1:0]   w_gnt_idx;
    logic                w_gnt_any;
    logic                w_loadable;
    logic                w_grant;
    logic [NUM_SRC-1:0]  w_clr;
    logic [NUM_SRC-1:0]  w_drop_vec;
    logic [2:0]          w_drop_num;
    logic [DROP_W+2:0]   w_drop_sum;

    prio_arb4 u_arb (
        .pending (pending_q),
        .rr_last (rr_last_q),
        .mode    (C_MODE),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    // Next-state logic: slot load/drain, pending update and drop counting
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        rr_last_d  = rr_last_q;
        w_clr      = '0;
        w_drop_num = '0;

        // Slot can accept a new event when empty or when the held one leaves
        w_loadable = (state_q == S_EMPTY) || bus.ready;
        w_grant    = w_loadable && w_gnt_any;

        if (w_loadable) begin
            if (w_gnt_any) begin
                state_d   = S_FULL;
                code_d    = w_gnt_idx;
                rr_last_d = w_gnt_idx;
                w_clr[w_gnt_idx] = 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end

        // A request landing on its own grant edge is a fresh event, not a drop
        pending_d  = (pending_q & ~w_clr) | bus.req;
        w_drop_vec = bus.req & pending_q & ~w_clr;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_drop_num = w_drop_num + {2'b00, w_drop_vec[i]};
        end

        w_drop_sum = {3'b000, drop_cnt_q} + {{DROP_W{1'b0}}, w_drop_num};
        if (w_drop_sum > {3'b000, C_DROP_MAX}) begin
            drop_cnt_d = C_DROP_MAX;
        end else begin
            drop_cnt_d = w_drop_sum[DROP_W-1:0];
        end
    end

    // State registers; reset discards any held or pending events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            code_q     <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
            rr_last_q  <= CODE_W'(NUM_SRC - 1);
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign bus.code     = code_q;
    assign bus.valid    = (state_q == S_FULL);
    assign bus.pending  = pending_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule : event_encoder4x2
`default_nettype wire

// File: tb/tb_event_encoder4x2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_encoder4x2
//  Description : Self-checking bench. Three encoder instances (fixed/8-bit,
//                round-robin/8-bit, fixed/2-bit counter) share one stimulus
//                stream and are each compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_encoder4x2;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;

    int total = 0;
    int bad   = 0;

    event_encoder4x2_if #(.DROP_W(8)) ifc_fix ();
    event_encoder4x2_if #(.DROP_W(8)) ifc_rr  ();
    event_encoder4x2_if #(.DROP_W(2)) ifc_sat ();

    assign ifc_fix.req = req;  assign ifc_fix.ready = ready;
    assign ifc_rr.req  = req;  assign ifc_rr.ready  = ready;
    assign ifc_sat.req = req;  assign ifc_sat.ready = ready;

    event_encoder4x2 #(.RR_MODE(0), .DROP_W(8)) dut_fix (.clk(clk), .rst(rst), .bus(ifc_fix));
    event_encoder4x2 #(.RR_MODE(1), .DROP_W(8)) dut_rr  (.clk(clk), .rst(rst), .bus(ifc_rr));
    event_encoder4x2 #(.RR_MODE(0), .DROP_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(ifc_sat));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, one slot per instance ----------------
    int        m_mode [3] = '{0, 1, 0};
    int        m_max  [3] = '{255, 255, 3};
    logic [3:0] m_pend[3];
    bit        m_full [3];
    int        m_code [3];
    int        m_last [3];
    int        m_drop [3];

    function automatic int pick(input int mode, input logic [3:0] p, input int last);
        if (mode == 0) begin
            for (int i = 3; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (p[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                m_pend[n] = 4'b0000; m_full[n] = 1'b0; m_code[n] = 0;
                m_last[n] = 3;       m_drop[n] = 0;
            end else begin
                int g;
                int cnt;
                logic [3:0] np;
                g = -1;
                if (!m_full[n] || ready) begin
                    g = pick(m_mode[n], m_pend[n], m_last[n]);
                    if (g >= 0) begin
                        m_full[n] = 1'b1; m_code[n] = g; m_last[n] = g;
                    end else begin
                        m_full[n] = 1'b0;
                    end
                end
                cnt = 0;
                for (int i = 0; i < 4; i++) begin
                    if (req[i] && m_pend[n][i] && i != g) cnt++;
                    np[i] = (m_pend[n][i] && i != g) || req[i];
                end
                m_pend[n] = np;
                m_drop[n] = (m_drop[n] + cnt > m_max[n]) ? m_max[n] : m_drop[n] + cnt;
            end
        end
    end

    task automatic cmp(input int n, input string nm, input logic v, input logic [1:0] c,
                       input logic [3:0] p, input int d);
        chk({nm, ".valid"},   int'(v), int'(m_full[n]));
        if (m_full[n]) chk({nm, ".code"}, int'(c), m_code[n]);
        chk({nm, ".pending"}, int'(p), int'(m_pend[n]));
        chk({nm, ".drop_cnt"}, d, m_drop[n]);
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        cmp(0, "fix", ifc_fix.valid, ifc_fix.code, ifc_fix.pending, int'(ifc_fix.drop_cnt));
        cmp(1, "rr",  ifc_rr.valid,  ifc_rr.code,  ifc_rr.pending,  int'(ifc_rr.drop_cnt));
        cmp(2, "sat", ifc_sat.valid, ifc_sat.code, ifc_sat.pending, int'(ifc_sat.drop_cnt));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [3:0] r, input logic rd);
        @(posedge clk);
        #1;
        req   = r;
        ready = rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; req = 4'b0000; ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1. async reset in the middle of operation
        step(4'b0010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b0000, 1'b0);
        chk("t1.pend_before",  int'(ifc_fix.pending), 10);
        chk("t1.valid_before", int'(ifc_fix.valid),   1);
        chk("t1.code_before",  int'(ifc_fix.code),    1);
        #2 rst = 1'b1;
        #1;
        chk("t1.async_valid", int'(ifc_fix.valid),   0);
        chk("t1.async_pend",  int'(ifc_fix.pending), 0);
        chk("t1.async_code",  int'(ifc_rr.code),     0);
        @(posedge clk);
        #1 rst = 1'b0; ready = 1'b1;
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("t1.post_valid", int'(ifc_fix.valid),    0);
        chk("t1.post_drop",  int'(ifc_fix.drop_cnt), 0);

        // 2. single-cycle burst on all sources, fixed priority 3,2,1,0
        do_reset();
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        chk("t2.pend_e1", int'(ifc_fix.pending), 15);
        chk("t2.valid_e1", int'(ifc_fix.valid), 0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 1'b1);
            chk($sformatf("t2.fix_code%0d", k), int'(ifc_fix.code), 3 - k);
            chk($sformatf("t2.rr_code%0d",  k), int'(ifc_rr.code),  k);
            chk($sformatf("t2.valid%0d",    k), int'(ifc_fix.valid), 1);
        end
        step(4'b0000, 1'b1);
        chk("t2.valid_end", int'(ifc_fix.valid), 0);

        // 3. held requests: round-robin rotation, drops pile up, 2-bit counter saturates
        do_reset();
        step(4'b1111, 1'b1);
        for (int k = 1; k <= 5; k++) step(4'b1111, 1'b1);
        chk("t3.rr_code",  int'(ifc_rr.code),      3);
        chk("t3.rr_valid", int'(ifc_rr.valid),     1);
        chk("t3.rr_drop",  int'(ifc_rr.drop_cnt),  12);
        chk("t3.fix_code", int'(ifc_fix.code),     3);
        chk("t3.sat_drop", int'(ifc_sat.drop_cnt), 3);
        step(4'b1111, 1'b1);
        chk("t3.rr_code_wrap", int'(ifc_rr.code),      0);
        chk("t3.sat_hold",     int'(ifc_sat.drop_cnt), 3);
        step(4'b0000, 1'b1);

        // 4. backpressure holds the slot; re-request then drop
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 1'b0);
            chk("t4.hold_code",  int'(ifc_rr.code),  2);
            chk("t4.hold_valid", int'(ifc_fix.valid), 1);
        end
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        chk("t4.repend", int'(ifc_fix.pending),  4);
        chk("t4.nodrop", int'(ifc_fix.drop_cnt), 0);
        step(4'b0000, 1'b0);
        chk("t4.drop1", int'(ifc_fix.drop_cnt), 1);

        // 5. re-request on the grant edge keeps the source pending without a drop
        do_reset();
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("t5.code0",  int'(ifc_fix.code),     0);
        chk("t5.valid0", int'(ifc_fix.valid),    1);
        chk("t5.pend0",  int'(ifc_fix.pending),  1);
        chk("t5.drop0",  int'(ifc_fix.drop_cnt), 0);
        step(4'b0000, 1'b1);
        chk("t5.code1",  int'(ifc_fix.code),    0);
        chk("t5.valid1", int'(ifc_fix.valid),   1);
        chk("t5.pend1",  int'(ifc_fix.pending), 0);
        step(4'b0000, 1'b1);
        chk("t5.valid2", int'(ifc_fix.valid), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_event_encoder4x2
`default_nettype wire
